// File: rtl/vend_sequencer_pkg.sv
// Shared types and constants for the vending channel sequencer.
// Holds the machine-state encoding and the coin face values used when a refund
// is paid out as coins (CHANGE_COINS_EN builds only).
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_PAY    = 2'b01,
        S_VEND   = 2'b10,
        S_CANCEL = 2'b11
    } state_e;

    localparam logic [8:0] CENTS_DOLLAR  = 9'd100;
    localparam logic [8:0] CENTS_QUARTER = 9'd25;
    localparam logic [8:0] CENTS_DIME    = 9'd10;
    localparam logic [8:0] CENTS_NICKEL  = 9'd5;

endpackage

// File: rtl/vend_sequencer_if.sv
// Bundle of selection, restock, payment-handshake and motor/refund signals
// between the vending sequencer (slave) and its environment (master).
// Coin outputs are present only when CHANGE_COINS_EN is defined.
interface vend_sequencer_if #(
    parameter int NUM_ITEMS = 8,
    parameter int CNT_W     = 4
) ();
    logic                 sel_valid;
    logic [3:0]           sel_index;
    logic                 cancel_req;
    logic                 restock_valid;
    logic [3:0]           restock_index;
    logic [CNT_W-1:0]     restock_qty;
    logic                 reduce_inventory;
    logic                 cancelled_done;
    logic [8:0]           change;
    logic [1:0]           state;
    logic [3:0]           cur_index;
    logic                 cancelled;
    logic                 reduce_inventory_done;
    logic [NUM_ITEMS-1:0] vend_motor;
    logic                 sold_out;
    logic [NUM_ITEMS-1:0] empty_map;
    logic                 refund_valid;
    logic [8:0]           refund_amount;
`ifdef CHANGE_COINS_EN
    logic                 coin_dollar;
    logic                 coin_quarter;
    logic                 coin_dime;
    logic                 coin_nickel;
`endif

    modport slave (
        input  sel_valid, sel_index, cancel_req, restock_valid, restock_index,
               restock_qty, reduce_inventory, cancelled_done, change,
`ifdef CHANGE_COINS_EN
        output coin_dollar, coin_quarter, coin_dime, coin_nickel,
`endif
        output state, cur_index, cancelled, reduce_inventory_done, vend_motor,
               sold_out, empty_map, refund_valid, refund_amount
    );

    modport master (
        output sel_valid, sel_index, cancel_req, restock_valid, restock_index,
               restock_qty, reduce_inventory, cancelled_done, change,
`ifdef CHANGE_COINS_EN
        input  coin_dollar, coin_quarter, coin_dime, coin_nickel,
`endif
        input  state, cur_index, cancelled, reduce_inventory_done, vend_motor,
               sold_out, empty_map, refund_valid, refund_amount
    );
endinterface

// File: rtl/vend_sequencer_change_dispenser.sv
// Greedy coin decomposition of a captured refund: one coin pulse per cycle,
// largest coin first; a remainder below a nickel is dropped.
// Only instantiated when CHANGE_COINS_EN is defined.
module change_dispenser
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [8:0] amount_i,
    output logic       coin_dollar_o,
    output logic       coin_quarter_o,
    output logic       coin_dime_o,
    output logic       coin_nickel_o,
    output logic       busy_o
);
    logic [8:0] remain_q, remain_d;
    logic [3:0] coins_q, coins_d;   // {dollar, quarter, dime, nickel}

    // Pick the next coin and reduce the remaining amount.
    always_comb begin
        remain_d = remain_q;
        coins_d  = 4'b0000;
        if (load_i) begin
            remain_d = amount_i;
        end else if (remain_q >= CENTS_DOLLAR) begin
            remain_d = remain_q - CENTS_DOLLAR;
            coins_d  = 4'b1000;
        end else if (remain_q >= CENTS_QUARTER) begin
            remain_d = remain_q - CENTS_QUARTER;
            coins_d  = 4'b0100;
        end else if (remain_q >= CENTS_DIME) begin
            remain_d = remain_q - CENTS_DIME;
            coins_d  = 4'b0010;
        end else if (remain_q >= CENTS_NICKEL) begin
            remain_d = remain_q - CENTS_NICKEL;
            coins_d  = 4'b0001;
        end else begin
            remain_d = remain_q;
        end
    end

    // Remaining amount and registered coin pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= 9'd0;
            coins_q  <= 4'b0000;
        end else begin
            remain_q <= remain_d;
            coins_q  <= coins_d;
        end
    end

    assign coin_dollar_o  = coins_q[3];
    assign coin_quarter_o = coins_q[2];
    assign coin_dime_o    = coins_q[1];
    assign coin_nickel_o  = coins_q[0];
    assign busy_o         = (remain_q >= CENTS_NICKEL);
endmodule

// File: rtl/vend_sequencer.sv
// Sequencer for one vending channel: selection, per-slot inventory, payment
// timeout, motor drive and refund handshake with the payment block.
// Optional feature macro: CHANGE_COINS_EN (refund paid out as coin pulses).
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS      = 8,
    parameter int CNT_W          = 4,
    parameter int INIT_COUNT     = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MOTOR_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst,     // asynchronous, active low
    vend_sequencer_if.slave   bus
);
    localparam int IDX_W   = $clog2(NUM_ITEMS);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int MCNT_W  = $clog2(MOTOR_CYCLES + 1);

    state_e                          state_q, state_d;
    logic [3:0]                      cur_index_q, cur_index_d;
    logic [NUM_ITEMS-1:0][CNT_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0]              timer_q, timer_d;
    logic [MCNT_W-1:0]               mcnt_q, mcnt_d;
    logic [NUM_ITEMS-1:0]            motor_q, motor_d;
    logic                            cancelled_q, cancelled_d;
    logic                            done_q, done_d;
    logic                            sold_out_q, sold_out_d;
    logic                            refund_valid_q, refund_valid_d;
    logic [8:0]                      refund_amount_q, refund_amount_d;
    logic                            coins_idle_s;
    logic                            capture_s;
    logic [IDX_W-1:0]                cur_idx_s, sel_idx_s, rst_idx_s;

    // Saturating unsigned add done one bit wider, then clamped.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) return {CNT_W{1'b1}};
        else            return sum[CNT_W-1:0];
    endfunction

    assign cur_idx_s = cur_index_q[IDX_W-1:0];
    assign sel_idx_s = bus.sel_index[IDX_W-1:0];
    assign rst_idx_s = bus.restock_index[IDX_W-1:0];
    assign capture_s = (state_q == S_CANCEL) && cancelled_q && bus.cancelled_done;

`ifdef CHANGE_COINS_EN
    logic coin_busy_s;

    change_dispenser u_change (
        .clk            (clk),
        .rst_n          (rst),
        .load_i         (capture_s),
        .amount_i       (bus.change),
        .coin_dollar_o  (bus.coin_dollar),
        .coin_quarter_o (bus.coin_quarter),
        .coin_dime_o    (bus.coin_dime),
        .coin_nickel_o  (bus.coin_nickel),
        .busy_o         (coin_busy_s)
    );
    assign coins_idle_s = !coin_busy_s;
`else
    assign coins_idle_s = 1'b1;
`endif

    // Next-state, inventory and output-register logic for the channel FSM.
    always_comb begin
        state_d         = state_q;
        cur_index_d     = cur_index_q;
        count_d         = count_q;
        timer_d         = timer_q;
        mcnt_d          = mcnt_q;
        motor_d         = motor_q;
        cancelled_d     = cancelled_q;
        done_d          = done_q;
        sold_out_d      = 1'b0;
        refund_valid_d  = 1'b0;
        refund_amount_d = refund_amount_q;
        case (state_q)
            S_IDLE: begin
                // Restock wins over a same-cycle selection.
                if (bus.restock_valid) begin
                    if (32'(bus.restock_index) < NUM_ITEMS) begin
                        count_d[rst_idx_s] = sat_add(count_q[rst_idx_s], bus.restock_qty);
                    end else begin
                        count_d = count_q;
                    end
                end else if (bus.sel_valid && (32'(bus.sel_index) < NUM_ITEMS)) begin
                    if (count_q[sel_idx_s] != {CNT_W{1'b0}}) begin
                        cur_index_d = bus.sel_index;
                        timer_d     = {TIMER_W{1'b0}};
                        state_d     = S_PAY;
                    end else begin
                        sold_out_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAY: begin
                timer_d = timer_q + TIMER_W'(1);
                if (bus.reduce_inventory) begin
                    state_d = S_VEND;
                    motor_d = NUM_ITEMS'(1) << cur_idx_s;
                    mcnt_d  = {MCNT_W{1'b0}};
                end else if (bus.cancel_req || (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d     = S_CANCEL;
                    cancelled_d = 1'b1;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_VEND: begin
                if (motor_q != {NUM_ITEMS{1'b0}}) begin
                    if (mcnt_q == {MCNT_W{1'b0}}) begin
                        count_d[cur_idx_s] = count_q[cur_idx_s] - CNT_W'(1);
                    end else begin
                        count_d = count_q;
                    end
                    if (mcnt_q == MCNT_W'(MOTOR_CYCLES - 1)) begin
                        motor_d = {NUM_ITEMS{1'b0}};
                        done_d  = 1'b1;
                    end else begin
                        mcnt_d  = mcnt_q + MCNT_W'(1);
                    end
                end else if (done_q && !bus.reduce_inventory) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_VEND;
                end
            end
            S_CANCEL: begin
                if (capture_s) begin
                    refund_amount_d = bus.change;
                    refund_valid_d  = 1'b1;
                    cancelled_d     = 1'b0;
                end else if (!cancelled_q && !bus.cancelled_done && coins_idle_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CANCEL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cur_index_q     <= 4'd0;
            count_q         <= {NUM_ITEMS{CNT_W'(INIT_COUNT)}};
            timer_q         <= {TIMER_W{1'b0}};
            mcnt_q          <= {MCNT_W{1'b0}};
            motor_q         <= {NUM_ITEMS{1'b0}};
            cancelled_q     <= 1'b0;
            done_q          <= 1'b0;
            sold_out_q      <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= 9'd0;
        end else begin
            state_q         <= state_d;
            cur_index_q     <= cur_index_d;
            count_q         <= count_d;
            timer_q         <= timer_d;
            mcnt_q          <= mcnt_d;
            motor_q         <= motor_d;
            cancelled_q     <= cancelled_d;
            done_q          <= done_d;
            sold_out_q      <= sold_out_d;
            refund_valid_q  <= refund_valid_d;
            refund_amount_q <= refund_amount_d;
        end
    end

    // Empty-slot map derived from the inventory registers.
    always_comb begin
        bus.empty_map = {NUM_ITEMS{1'b0}};
        for (int i = 0; i < NUM_ITEMS; i++) begin
            bus.empty_map[i] = (count_q[i] == {CNT_W{1'b0}});
        end
    end

    assign bus.state                 = state_q;
    assign bus.cur_index             = cur_index_q;
    assign bus.cancelled             = cancelled_q;
    assign bus.reduce_inventory_done = done_q;
    assign bus.vend_motor            = motor_q;
    assign bus.sold_out              = sold_out_q;
    assign bus.refund_valid          = refund_valid_q;
    assign bus.refund_amount         = refund_amount_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: reset, normal vend, sold out, cancel
// refund, payment timeout, vend/cancel race with restock saturation, and
// asynchronous reset in the middle of a vend.
module tb_vend_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    vend_sequencer_if #(.NUM_ITEMS(8), .CNT_W(4)) vif ();

    vend_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vif.sel_valid        = 1'b0;
        vif.sel_index        = 4'd0;
        vif.cancel_req       = 1'b0;
        vif.restock_valid    = 1'b0;
        vif.restock_index    = 4'd0;
        vif.restock_qty      = 4'd0;
        vif.reduce_inventory = 1'b0;
        vif.cancelled_done   = 1'b0;
        vif.change           = 9'd0;
    endtask

    // Select a slot, pay, and wait (bounded) for the dispense to complete.
    task automatic vend_once(input logic [3:0] idx);
        int n;
        vif.sel_valid = 1'b1;
        vif.sel_index = idx;
        tick();
        vif.sel_valid = 1'b0;
        vif.reduce_inventory = 1'b1;
        n = 0;
        while (!vif.reduce_inventory_done && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (vif.reduce_inventory_done !== 1'b1)
            $display("FAIL vend_done slot %0d: done=%b required 1", idx, vif.reduce_inventory_done);
        else passed++;
        vif.reduce_inventory = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++; if (vif.state !== 2'b00) $display("FAIL rst_state: got %b want 00", vif.state); else passed++;
        checks++; if (vif.cur_index !== 4'd0) $display("FAIL rst_cur_index: got %0d want 0", vif.cur_index); else passed++;
        checks++; if ({vif.cancelled, vif.reduce_inventory_done, vif.sold_out, vif.refund_valid} !== 4'b0000)
            $display("FAIL rst_flags: got %b want 0000", {vif.cancelled, vif.reduce_inventory_done, vif.sold_out, vif.refund_valid}); else passed++;
        checks++; if (vif.vend_motor !== 8'h00) $display("FAIL rst_motor: got %h want 00", vif.vend_motor); else passed++;
        checks++; if (vif.refund_amount !== 9'd0) $display("FAIL rst_refund: got %0d want 0", vif.refund_amount); else passed++;
        checks++; if (vif.empty_map !== 8'h00) $display("FAIL rst_empty_map: got %h want 00", vif.empty_map); else passed++;
        checks++; if (dut.count_q[7] !== 4'd5) $display("FAIL rst_count7: got %0d want 5", dut.count_q[7]); else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_normal_vend();
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd3;
        tick();
        vif.sel_valid = 1'b0;
        checks++; if (vif.state !== 2'b01) $display("FAIL vend_pay_state: got %b want 01", vif.state); else passed++;
        checks++; if (vif.cur_index !== 4'd3) $display("FAIL vend_cur_index: got %0d want 3", vif.cur_index); else passed++;
        vif.reduce_inventory = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (vif.state !== 2'b10) $display("FAIL vend_state c%0d: got %b want 10", i, vif.state); else passed++;
            checks++; if (vif.vend_motor !== 8'b0000_1000) $display("FAIL vend_motor c%0d: got %b want 00001000", i, vif.vend_motor); else passed++;
        end
        tick();
        checks++; if (vif.vend_motor !== 8'h00) $display("FAIL vend_motor_off: got %b want 0", vif.vend_motor); else passed++;
        checks++; if (vif.reduce_inventory_done !== 1'b1) $display("FAIL vend_done: got %b want 1", vif.reduce_inventory_done); else passed++;
        tick();
        checks++; if (vif.reduce_inventory_done !== 1'b1) $display("FAIL vend_done_hold: got %b want 1", vif.reduce_inventory_done); else passed++;
        vif.reduce_inventory = 1'b0;
        tick();
        checks++; if (vif.reduce_inventory_done !== 1'b0) $display("FAIL vend_done_drop: got %b want 0", vif.reduce_inventory_done); else passed++;
        checks++; if (vif.state !== 2'b00) $display("FAIL vend_idle: got %b want 00", vif.state); else passed++;
        checks++; if (dut.count_q[3] !== 4'd4) $display("FAIL vend_count3: got %0d want 4", dut.count_q[3]); else passed++;
    endtask

    task automatic test_sold_out();
        for (int i = 0; i < 5; i++) vend_once(4'd0);
        checks++; if (vif.empty_map !== 8'b0000_0001) $display("FAIL so_empty_map: got %b want 00000001", vif.empty_map); else passed++;
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd0;
        tick();
        vif.sel_valid = 1'b0;
        checks++; if (vif.sold_out !== 1'b1) $display("FAIL so_pulse: got %b want 1", vif.sold_out); else passed++;
        checks++; if (vif.state !== 2'b00) $display("FAIL so_state: got %b want 00", vif.state); else passed++;
        tick();
        checks++; if (vif.sold_out !== 1'b0) $display("FAIL so_pulse_end: got %b want 0", vif.sold_out); else passed++;
        // out-of-range selection is ignored
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd9;
        tick();
        vif.sel_valid = 1'b0;
        checks++; if ({vif.state, vif.sold_out} !== 3'b000) $display("FAIL so_bad_index: got %b want 000", {vif.state, vif.sold_out}); else passed++;
    endtask

    task automatic test_cancel();
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd2;
        tick();
        vif.sel_valid = 1'b0;
        vif.cancel_req = 1'b1;
        tick();
        vif.cancel_req = 1'b0;
        checks++; if (vif.state !== 2'b11) $display("FAIL cxl_state: got %b want 11", vif.state); else passed++;
        checks++; if (vif.cancelled !== 1'b1) $display("FAIL cxl_cancelled: got %b want 1", vif.cancelled); else passed++;
        tick();
        vif.cancelled_done = 1'b1;
        vif.change = 9'd135;
        tick();
        checks++; if (vif.refund_valid !== 1'b1) $display("FAIL cxl_refund_valid: got %b want 1", vif.refund_valid); else passed++;
        checks++; if (vif.refund_amount !== 9'd135) $display("FAIL cxl_refund_amount: got %0d want 135", vif.refund_amount); else passed++;
        checks++; if (vif.cancelled !== 1'b0) $display("FAIL cxl_cancel_drop: got %b want 0", vif.cancelled); else passed++;
`ifdef CHANGE_COINS_EN
        begin
            logic [3:0] exp_coins [0:3];
            exp_coins[0] = 4'b1000;
            exp_coins[1] = 4'b0100;
            exp_coins[2] = 4'b0010;
            exp_coins[3] = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({vif.coin_dollar, vif.coin_quarter, vif.coin_dime, vif.coin_nickel} !== exp_coins[i])
                    $display("FAIL cxl_coin%0d: got %b want %b", i,
                             {vif.coin_dollar, vif.coin_quarter, vif.coin_dime, vif.coin_nickel}, exp_coins[i]);
                else passed++;
            end
        end
`else
        tick();
`endif
        checks++; if ({vif.refund_valid, vif.state} !== 3'b011) $display("FAIL cxl_hold: got %b want 011", {vif.refund_valid, vif.state}); else passed++;
        vif.cancelled_done = 1'b0;
        tick();
        checks++; if (vif.state !== 2'b00) $display("FAIL cxl_idle: got %b want 00", vif.state); else passed++;
        checks++; if (vif.refund_amount !== 9'd135) $display("FAIL cxl_amount_kept: got %0d want 135", vif.refund_amount); else passed++;
    endtask

    task automatic test_timeout();
        int n;
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd1;
        tick();
        vif.sel_valid = 1'b0;
        n = 0;
        while (vif.state !== 2'b11 && n < 1100) begin
            tick();
            n++;
        end
        checks++; if (n !== 1000) $display("FAIL to_cycles: got %0d want 1000", n); else passed++;
        checks++; if (vif.cancelled !== 1'b1) $display("FAIL to_cancelled: got %b want 1", vif.cancelled); else passed++;
        vif.cancelled_done = 1'b1;
        vif.change = 9'd0;
        tick();
        vif.cancelled_done = 1'b0;
        tick();
        tick();
        checks++; if (vif.state !== 2'b00) $display("FAIL to_idle: got %b want 00", vif.state); else passed++;
    endtask

    task automatic test_race_restock();
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd4;
        tick();
        vif.sel_valid = 1'b0;
        vif.reduce_inventory = 1'b1;
        vif.cancel_req = 1'b1;
        tick();
        vif.cancel_req = 1'b0;
        checks++; if (vif.state !== 2'b10) $display("FAIL race_state: got %b want 10", vif.state); else passed++;
        checks++; if (vif.cancelled !== 1'b0) $display("FAIL race_cancelled: got %b want 0", vif.cancelled); else passed++;
        for (int i = 0; i < 5; i++) tick();
        vif.reduce_inventory = 1'b0;
        tick();
        checks++; if (dut.count_q[4] !== 4'd4) $display("FAIL race_count4: got %0d want 4", dut.count_q[4]); else passed++;
        vif.restock_valid = 1'b1;
        vif.restock_index = 4'd4;
        vif.restock_qty   = 4'd15;
        vif.sel_valid     = 1'b1;
        vif.sel_index     = 4'd4;
        tick();
        vif.restock_valid = 1'b0;
        vif.sel_valid     = 1'b0;
        checks++; if (dut.count_q[4] !== 4'd15) $display("FAIL restock_sat: got %0d want 15", dut.count_q[4]); else passed++;
        checks++; if (vif.state !== 2'b00) $display("FAIL restock_sel_dropped: got %b want 00", vif.state); else passed++;
    endtask

    task automatic test_reset_mid_vend();
        vif.sel_valid = 1'b1;
        vif.sel_index = 4'd5;
        tick();
        vif.sel_valid = 1'b0;
        vif.reduce_inventory = 1'b1;
        tick();
        tick();
        checks++; if (vif.vend_motor !== 8'b0010_0000) $display("FAIL mid_motor: got %b want 00100000", vif.vend_motor); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (vif.vend_motor !== 8'h00) $display("FAIL mid_rst_motor: got %b want 0", vif.vend_motor); else passed++;
        checks++; if (vif.state !== 2'b00) $display("FAIL mid_rst_state: got %b want 00", vif.state); else passed++;
        checks++; if (dut.count_q[0] !== 4'd5) $display("FAIL mid_rst_count0: got %0d want 5", dut.count_q[0]); else passed++;
        checks++; if (dut.count_q[4] !== 4'd5) $display("FAIL mid_rst_count4: got %0d want 5", dut.count_q[4]); else passed++;
        vif.reduce_inventory = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_normal_vend();
        test_sold_out();
        test_cancel();
        test_timeout();
        test_race_restock();
        test_reset_mid_vend();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
